// File: rtl/comparator_serial.sv
`default_nettype none
// ============================================================================
// Module      : comparator_serial
// Description : Bit-serial (LSB-first) equality / less-than comparator with
//               valid/ready request and response channels; N-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module comparator_serial #(
  parameter int N      = 32,
  parameter int SIGNED = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         equals,
  output logic         less_than
);

  localparam int              c_CW   = $clog2(N) + 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [c_CW-1:0] r_cnt;
  logic            r_eq_acc;
  logic            r_lt_acc;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_equals;
  logic            r_less_than;

  logic            w_last;
  logic            w_eq_nxt;
  logic            w_lt_nxt;

  assign w_last = (r_cnt == c_LAST);

  // The first differing bit seen from the MSB side wins, so later (higher)
  // bits simply overwrite the accumulator. The sign bit inverts the sense.
  always_comb begin
    w_eq_nxt = r_eq_acc;
    w_lt_nxt = r_lt_acc;
    if (r_a[0] != r_b[0]) begin
      w_eq_nxt = 1'b0;
      w_lt_nxt = (SIGNED != 0 && w_last) ? r_a[0] : r_b[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_cnt       <= '0;
      r_eq_acc    <= 1'b0;
      r_lt_acc    <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_equals    <= 1'b0;
      r_less_than <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_eq_acc   <= 1'b1;
            r_lt_acc   <= 1'b0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_eq_acc <= w_eq_nxt;
          r_lt_acc <= w_lt_nxt;
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_equals    <= w_eq_nxt;
            r_less_than <= w_lt_nxt;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign equals    = r_equals;
  assign less_than = r_less_than;

endmodule
`default_nettype wire

// File: tb/tb_comparator_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_comparator_serial
// Description : Randomized self-checking bench for comparator_serial against a
//               plain-arithmetic compare model (N=32 signed/unsigned, N=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_comparator_serial;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, equals, less_than;
  logic [N-1:0] a, b;
  logic         iv_u, ir_u, ov_u, or_u, eq_u, lt_u;
  logic [N-1:0] a_u, b_u;
  logic         iv_1, ir_1, ov_1, or_1, eq_1, lt_1;
  logic [0:0]   a_1, b_1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_accept = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  comparator_serial #(.N(N), .SIGNED(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .equals(equals), .less_than(less_than)
  );

  comparator_serial #(.N(N), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst(rst), .in_valid(iv_u), .in_ready(ir_u), .a(a_u), .b(b_u),
    .out_valid(ov_u), .out_ready(or_u), .equals(eq_u), .less_than(lt_u)
  );

  comparator_serial #(.N(1), .SIGNED(1)) u_dut_1 (
    .clk(clk), .rst(rst), .in_valid(iv_1), .in_ready(ir_1), .a(a_1), .b(b_1),
    .out_valid(ov_1), .out_ready(or_1), .equals(eq_1), .less_than(lt_1)
  );

  function automatic logic ref_lt(input logic [N-1:0] x, input logic [N-1:0] y, input bit sgn);
    if (sgn) return $signed(x) < $signed(y);
    return x < y;
  endfunction

  // Caller is positioned just after a negedge with the DUT idle.
  task automatic do_cmp(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input int stall, input string nm);
    int   lat;
    logic e_eq, e_lt;
    e_eq = (ta == tb_v);
    e_lt = ref_lt(ta, tb_v, 1'b1);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready_before_req: got %b want 1", nm, in_ready);
    end
    in_valid = 1'b1; a = ta; b = tb_v;
    @(posedge clk); #1;
    if (last_accept >= 0) begin
      checks++;
      if (cyc - last_accept < N + 2) begin
        errors++; $display("FAIL %s issue_interval: got %0d want >= %0d", nm, cyc - last_accept, N + 2);
      end
    end
    last_accept = cyc;
    lat = 0;
    while (1) begin
      @(negedge clk);
      if (out_valid === 1'b1 || lat > 4 * N) break;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL %s busy_ready: got %b want 0 at lat %0d", nm, in_ready, lat);
      end
      in_valid = 1'($urandom); a = $urandom; b = $urandom;
      @(posedge clk); lat++;
    end
    checks++;
    if (lat !== N) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", nm, lat, N);
    end
    checks++;
    if ({equals, less_than} !== {e_eq, e_lt}) begin
      errors++; $display("FAIL %s result a=%h b=%h: got eq=%b lt=%b want eq=%b lt=%b", nm, ta, tb_v, equals, less_than, e_eq, e_lt);
    end
    out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'($urandom); a = $urandom; b = $urandom;
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, equals, less_than} !== {1'b1, 1'b0, e_eq, e_lt}) begin
        errors++; $display("FAIL %s stall%0d: got ov=%b ir=%b eq=%b lt=%b want ov=1 ir=0 eq=%b lt=%b", nm, s, out_valid, in_ready, equals, less_than, e_eq, e_lt);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready, equals, less_than} !== {1'b0, 1'b1, e_eq, e_lt}) begin
      errors++; $display("FAIL %s consume: got ov=%b ir=%b eq=%b lt=%b want ov=0 ir=1 eq=%b lt=%b", nm, out_valid, in_ready, equals, less_than, e_eq, e_lt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    iv_u = 1'b0; or_u = 1'b0; a_u = '0; b_u = '0;
    iv_1 = 1'b0; or_1 = 1'b0; a_1 = '0; b_1 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, equals, less_than} !== 4'b1000) begin
      errors++; $display("FAIL reset_main: got ir=%b ov=%b eq=%b lt=%b want 1000", in_ready, out_valid, equals, less_than);
    end
    checks++;
    if ({ir_u, ov_u, eq_u, lt_u, ir_1, ov_1, eq_1, lt_1} !== 8'b1000_1000) begin
      errors++; $display("FAIL reset_aux: got %b want 10001000", {ir_u, ov_u, eq_u, lt_u, ir_1, ov_1, eq_1, lt_1});
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, equals, less_than} !== 4'b1000) begin
      errors++; $display("FAIL idle_after_reset: got ir=%b ov=%b eq=%b lt=%b want 1000", in_ready, out_valid, equals, less_than);
    end
  endtask

  task automatic test_equal();
    do_cmp(32'd0, 32'd0, 0, "eq_zero");
    do_cmp(32'd38273, 32'd38273, 0, "eq_38273");
    do_cmp(32'h0000_0001, 32'h0000_0000, 0, "diff_lsb");
  endtask

  task automatic test_abort_reset();
    bit seen_ov;
    do_cmp(32'h0000_5555, 32'h0000_5555, 0, "pre_abort");
    in_valid = 1'b1; a = 32'd3; b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    last_accept = -1;
    checks++;
    if ({in_ready, out_valid, equals, less_than} !== 4'b1000) begin
      errors++; $display("FAIL abort_reset: got ir=%b ov=%b eq=%b lt=%b want 1000", in_ready, out_valid, equals, less_than);
    end
    seen_ov = 1'b0;
    repeat (2 * N) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen_ov = 1'b1;
    end
    checks++;
    if (seen_ov !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL abort_no_result: got ov_seen=%b ir=%b want 0 1", seen_ov, in_ready);
    end
  endtask

  task automatic test_signed();
    do_cmp(32'hFFFF_FFFF, 32'h0000_0001, 0, "s_m1_lt_1");
    do_cmp(32'h0000_0001, 32'hFFFF_FFFF, 0, "s_1_lt_m1");
    do_cmp(32'h8000_0000, 32'h7FFF_FFFF, 0, "s_min_lt_max");
    do_cmp(32'h7FFF_FFFF, 32'h8000_0000, 0, "s_max_lt_min");
  endtask

  task automatic test_unsigned();
    logic [N-1:0] x, y;
    logic         e_eq, e_lt;
    for (int i = 0; i < 40; i++) begin
      x = (i == 0) ? 32'hFFFF_FFFF : (i == 1) ? 32'h8000_0000 : 32'($urandom);
      y = (i == 0) ? 32'h0000_0001 : (i == 1) ? 32'h7FFF_FFFF : ((i % 5) == 2) ? x : 32'($urandom);
      e_eq = (x == y);
      e_lt = ref_lt(x, y, 1'b0);
      iv_u = 1'b1; a_u = x; b_u = y;
      @(posedge clk); #1;
      iv_u = 1'b0; a_u = $urandom; b_u = $urandom;
      repeat (N) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({ov_u, eq_u, lt_u} !== {1'b1, e_eq, e_lt}) begin
        errors++; $display("FAIL unsigned a=%h b=%h: got ov=%b eq=%b lt=%b want ov=1 eq=%b lt=%b", x, y, ov_u, eq_u, lt_u, e_eq, e_lt);
      end
      or_u = 1'b1;
      @(negedge clk);
      or_u = 1'b0;
    end
  endtask

  task automatic test_n1();
    logic [0:0] x, y;
    logic       e_eq, e_lt;
    for (int i = 0; i < 4; i++) begin
      x = 1'(i >> 1);
      y = 1'(i);
      e_eq = (x == y);
      e_lt = $signed(x) < $signed(y);
      iv_1 = 1'b1; a_1 = x; b_1 = y;
      @(posedge clk); #1;
      iv_1 = 1'b0; a_1 = ~x; b_1 = ~y;
      @(negedge clk);
      checks++;
      if ({ov_1, ir_1} !== 2'b00) begin
        errors++; $display("FAIL n1_shift a=%b b=%b: got ov=%b ir=%b want 0 0", x, y, ov_1, ir_1);
      end
      @(negedge clk);
      checks++;
      if ({ov_1, eq_1, lt_1} !== {1'b1, e_eq, e_lt}) begin
        errors++; $display("FAIL n1 a=%b b=%b: got ov=%b eq=%b lt=%b want ov=1 eq=%b lt=%b", x, y, ov_1, eq_1, lt_1, e_eq, e_lt);
      end
      or_1 = 1'b1;
      @(negedge clk);
      or_1 = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    do_cmp(32'h0000_1234, 32'h0000_1235, 20, "bp_lt");
    do_cmp(32'hCAFE_0000, 32'hCAFE_0000, 20, "bp_eq");
  endtask

  task automatic test_random();
    logic [N-1:0] x, y;
    for (int i = 0; i < 1000; i++) begin
      x = $urandom;
      y = ($urandom_range(0, 7) == 0) ? x : 32'($urandom);
      do_cmp(x, y, $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    #3_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_equal();
    test_abort_reset();
    test_signed();
    test_unsigned();
    test_n1();
    test_backpressure();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/comparator_serial.md
# comparator_serial

Area-reduced, multi-cycle equality and less-than comparator for the datapath. It latches two N-bit operands on a valid/ready request and walks them one bit per cycle, LSB first. It returns `equals` and `less_than` on a valid/ready response channel, producing the same results as the combinational `comparator_eq`/`comparator_lt` pair. It serves as the responder for any requester that can tolerate an N-cycle compare latency.

## Interface
- `N`, default 32: operand width; legal range N ≥ 1.
- `SIGNED`, default 1: 1 = two's-complement less-than; 0 = unsigned less-than.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  requester presents operands.
- `in_ready`  out  1  block can accept operands.
- `a`  in  N  operand A; sampled only at request handshake.
- `b`  in  N  operand B; sampled only at request handshake.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  requester consumes result.
- `equals`  out  1  a == b.
- `less_than`  out  1  a < b, signedness per `SIGNED`.

## Operation
- States: IDLE, SHIFT, DONE. The state register and bit counter (width $clog2(N)+1) are the only control state.
- IDLE
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid && in_ready`, latch a and b into shift registers, set eq_acc=1, lt_acc=0, counter=0, and go to SHIFT.
- SHIFT, one bit i per cycle, i = counter, taken from the LSB of each shift register:
  - If a_i == b_i: accumulators unchanged.
  - Else, for i < N-1, or for i = N-1 with SIGNED=0: eq_acc←0, lt_acc←b_i.
  - Else, for i = N-1 with SIGNED=1 (sign bit): eq_acc←0, lt_acc←a_i.
  - Shift both registers right; counter++. After bit N-1 is processed, go to DONE.
- DONE
  - `out_valid`=1; `equals`=eq_acc, `less_than`=lt_acc, held stable until consumed.
  - On `out_valid && out_ready`, go to IDLE.
- Changes to `a`/`b` outside the accepting edge have no effect on the in-flight compare.
- `in_valid` is ignored outside IDLE. There is no queuing and no back-to-back overlap.

## Timing
- Reset (`rst`=0 at an edge) applies the following values from the next cycle, regardless of current state, and aborts any in-flight compare:
  - state=IDLE, `in_ready`=1, `out_valid`=0, `equals`=0, `less_than`=0, counter=0.
- Request accepted at edge k, then:
  - Edges k+1 … k+N process bits 0 … N-1.
  - Edge k+N enters DONE, so `out_valid`=1 in the cycle after edge k+N.
  - Latency is exactly N cycles from acceptance to result, independent of data.
- Result consumed at edge m gives `out_valid`=0 and `in_ready`=1 in the cycle after edge m. The next request can be accepted at edge m+1.
- Minimum issue interval: N+2 cycles (out_ready held high).
- `out_ready` low: DONE persists indefinitely, and outputs must not glitch or change.
- `in_ready` and `out_valid` are decoded from state only; no combinational path from inputs to outputs.
- N=1: a single SHIFT cycle processing only the sign/MSB bit, under the rules above.
- `equals`/`less_than` are don't-care-free: they hold their last value outside DONE, and are 0 after reset.

## Test plan
- Reset, then idle, N=32: `in_ready`=1, `out_valid`=0, `equals`=0, `less_than`=0. Assert `rst`=0 mid-SHIFT (cycle 10): IDLE next cycle, `out_valid` never rises.
- a=0, b=0 → exactly 32 cycles later `equals`=1, `less_than`=0; a=38273, b=38273 → `equals`=1, `less_than`=0.
- SIGNED=1: a=32'hFFFFFFFF (−1), b=1 → `less_than`=1; a=1, b=−1 → `less_than`=0; a=32'h80000000, b=32'h7FFFFFFF → `less_than`=1; reversed → 0.
- SIGNED=0: a=32'hFFFFFFFF, b=1 → `less_than`=0, `equals`=0.
- Backpressure: hold `out_ready`=0 for 20 cycles after `out_valid`, and toggle `a`/`b` and `in_valid` throughout. Required: results stable, `in_ready`=0, no second accept; release → IDLE next cycle.
- Random: 1000 $random pairs with random `out_ready` stalls, checked against the behavioural `a < b`/`a == b` on signed logic. Also check issue interval ≥ N+2 and zero errors.
